bin2bcd_seq: RTL and testbench
==============================

# bin2bcd_seq

Sequential binary-to-BCD converter using shift-and-add-3 (double dabble), one input bit per cycle. It sits downstream of the division circuit and upstream of the hex display multiplexer. The divider's `done_tick` drives `start`, and its zero-extended quotient or remainder drives `bin`. The block then presents four decimal digits to `hex3..hex0`, so results display in decimal instead of hex.

## Interface
- `W`, default 14: binary input width, legal range 1..14.
- `CBIT`, default 4: iteration counter width; must satisfy 2^CBIT > W.
- `clk`, input, 1: system clock; all state updates on its rising edge.
- `reset`, input, 1: synchronous, active-high; clears all registers on the next rising edge.
- `start`, input, 1: conversion request; sampled only in `idle`.
- `bin`, input, W: unsigned binary value; sampled only on the accepted `start` cycle.
- `ready`, output, 1: high while in `idle`.
- `done_tick`, output, 1: one-cycle pulse when a result is published.
- `ovf`, output, 1: registered; high if the last input exceeded 9999.
- `bcd3`, `bcd2`, `bcd1`, `bcd0`, output, 4 each: registered decimal digits, thousands to units.

## Operation
- FSM states: `idle`, `op`, `done`.
- In `idle`, when `start`=1 and `bin` <= 9999:
  - load the shift register with `bin`;
  - clear the working BCD registers;
  - set the iteration counter n = W;
  - go to `op`.
- In `idle`, when `start`=1 and `bin` > 9999:
  - set working digits to 9,9,9,9 and set working ovf = 1;
  - go directly to `done`.
- In `op`, each cycle:
  - every working digit > 4 gets +3 (4-bit, no carry out);
  - then shift left one bit through {digits, bin shift register}, MSB of bin entering `bcd0` bit 0;
  - n decrements by 1;
  - after the cycle with n = 1, go to `done`.
- In `done`:
  - copy the working digits and working ovf to the output registers;
  - assert `done_tick`;
  - return to `idle`.
- Outputs `bcd3..bcd0` and `ovf` change only in the `done` state. They hold the last result indefinitely, so the display never shows intermediate values.
- `start` in `op` or `done` is ignored, not queued.
- Inputs narrower than 14 bits are zero-extended by the integrator. If W < 14, overflow is impossible only when 2^W - 1 <= 9999; the comparison is still performed.

## Timing
- Reset values:
  - state `idle`, so `ready`=1;
  - `done_tick`=0, `ovf`=0;
  - `bcd3..bcd0`=0;
  - counter and working registers 0.
- Latency, with the start edge counted as cycle 0:
  - normal input: W cycles in `op`, then `done_tick` high in cycle W+1;
  - overflow input: `done_tick` high in cycle 1.
- Result visibility: new `bcd*` and `ovf` are visible on the same cycle as `done_tick`.
- `ready` timing:
  - falls the cycle after start is accepted;
  - stays low through the `done` cycle;
  - rises the cycle after `done_tick`.
- Throughput: one conversion per W+2 cycles. A `start` held high continuously restarts a conversion on every `idle` cycle.
- Reset mid-operation: the conversion is abandoned, outputs clear to 0 on the next edge, and no `done_tick` is issued.
- `start` coincident with `reset`: reset wins.

## Structure
- Shared package holds:
  - state encoding (`idle`, `op`, `done`);
  - `BCD_MAX` = 9999;
  - `NDIG` = 4;
  - the add-3 threshold value 4.
- One natural sub-module, `bcd_adj`: a combinational 4-bit "add 3 if > 4" cell, instantiated `NDIG` times on the working digits.
- Top-level integration: the divider `quo` and `rmd` each get their own instance, with outputs muxed by a switch ahead of `disp_hex_mux`.

## Test plan
- Zero input: after reset, `bin`=0 with a one-cycle `start` -> `done_tick` at cycle 15 (W=14); digits 0,0,0,0; `ovf`=0; `ready` back high at cycle 16.
- Typical values: `bin`=9999 -> 9,9,9,9 with `ovf`=0. `bin`=4097 -> 4,0,9,7. `bin`=255 (divider full-scale) -> 0,2,5,5.
- Overflow: `bin`=12345 -> `done_tick` at cycle 1; digits 9,9,9,9; `ovf`=1. A following `bin`=7 -> 0,0,0,7 with `ovf` cleared.
- Busy rejection: `start` pulses with different `bin` at cycles 3 and 15 of a conversion of 1234 -> only one `done_tick`, result 1,2,3,4. A `start` at cycle 16 (`idle`) is accepted.
- Reset mid-operation: `reset` asserted at cycle 6 of converting 8888 -> outputs 0, no `done_tick`. A fresh `start` with 42 then yields 0,0,4,2 at cycle 15.
- Result hold: after a result, `bin` toggles for 100 cycles without `start` -> `bcd*`, `ovf` and `ready` are unchanged.

Source files
------------

// File: rtl/bin2bcd_pkg.sv
// Shared definitions for the sequential binary-to-BCD converter:
// FSM state encoding, decimal limits and the add-3 correction helper.
package bin2bcd_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_OP   = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    // Largest value representable in four decimal digits
    localparam logic [31:0] BCD_MAX = 32'd9999;

    // Number of decimal digits produced
    localparam int NDIG = 4;

    // Digits above this value get +3 before each shift
    localparam logic [3:0] ADD3_THRESH = 4'd4;

    // Double-dabble digit correction: add 3 when the digit exceeds 4.
    // Result is kept to 4 bits; a corrected digit never exceeds 12.
    function automatic logic [3:0] add3_adj(input logic [3:0] digit);
        logic [3:0] res;
        if (digit > ADD3_THRESH) begin
            res = digit + 4'd3;
        end else begin
            res = digit;
        end
        return res;
    endfunction

endpackage

// File: rtl/bin2bcd_seq_bcd_adj.sv
// Combinational "add 3 if > 4" cell applied to one working BCD digit.
module bcd_adj
    import bin2bcd_pkg::*;
(
    input  logic [3:0] din,
    output logic [3:0] dout
);

    // Apply the double-dabble correction to a single digit
    always_comb begin
        dout = add3_adj(din);
    end

endmodule

// File: rtl/bin2bcd_seq.sv
// Sequential binary-to-BCD converter (double dabble, one bit per cycle).
// Out-of-range inputs (> 9999) saturate to 9999 with ovf set. Published
// digits and ovf only change when a result is released, so a display
// driven from them never sees intermediate values.
module bin2bcd_seq
    import bin2bcd_pkg::*;
#(
    parameter int W    = 14,
    parameter int CBIT = 4
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         start,
    input  logic [W-1:0] bin,
    output logic         ready,
    output logic         done_tick,
    output logic         ovf,
    output logic [3:0]   bcd3,
    output logic [3:0]   bcd2,
    output logic [3:0]   bcd1,
    output logic [3:0]   bcd0
);

    state_t               state_r, state_next_s;
    logic [W-1:0]         bin_r, bin_next_s;
    logic [NDIG*4-1:0]    wdig_r, wdig_next_s;
    logic [NDIG*4-1:0]    adj_s;
    logic                 wovf_r, wovf_next_s;
    logic [CBIT-1:0]      n_r, n_next_s;
    logic [NDIG*4-1:0]    bcd_r;
    logic                 ovf_r;
    logic                 ready_r;
    logic                 done_tick_r;

    // One correction cell per working digit
    for (genvar i = 0; i < NDIG; i++) begin : g_adj
        bcd_adj u_adj (
            .din  (wdig_r[i*4 +: 4]),
            .dout (adj_s[i*4 +: 4])
        );
    end

    // Next-state and working-register update logic
    always_comb begin
        state_next_s = state_r;
        bin_next_s   = bin_r;
        wdig_next_s  = wdig_r;
        wovf_next_s  = wovf_r;
        n_next_s     = n_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    if (32'(bin) > BCD_MAX) begin
                        // Saturate: skip the conversion entirely
                        wdig_next_s  = {NDIG{4'd9}};
                        wovf_next_s  = 1'b1;
                        state_next_s = ST_DONE;
                    end else begin
                        bin_next_s   = bin;
                        wdig_next_s  = '0;
                        wovf_next_s  = 1'b0;
                        n_next_s     = CBIT'(W);
                        state_next_s = ST_OP;
                    end
                end else begin
                    state_next_s = ST_IDLE;
                end
            end
            ST_OP: begin
                // Corrected digits and shift register move left as one word
                {wdig_next_s, bin_next_s} = {adj_s[NDIG*4-2:0], bin_r, 1'b0};
                n_next_s = n_r - CBIT'(1);
                if (n_r == CBIT'(1)) begin
                    state_next_s = ST_DONE;
                end else begin
                    state_next_s = ST_OP;
                end
            end
            ST_DONE: begin
                state_next_s = ST_IDLE;
            end
            default: begin
                state_next_s = ST_IDLE;
            end
        endcase
    end

    // State, working registers and published outputs
    always_ff @(posedge clk) begin
        if (reset) begin
            state_r     <= ST_IDLE;
            bin_r       <= '0;
            wdig_r      <= '0;
            wovf_r      <= 1'b0;
            n_r         <= '0;
            bcd_r       <= '0;
            ovf_r       <= 1'b0;
            ready_r     <= 1'b1;
            done_tick_r <= 1'b0;
        end else begin
            state_r     <= state_next_s;
            bin_r       <= bin_next_s;
            wdig_r      <= wdig_next_s;
            wovf_r      <= wovf_next_s;
            n_r         <= n_next_s;
            ready_r     <= (state_next_s == ST_IDLE);
            done_tick_r <= (state_next_s == ST_DONE);
            // Publish on entry to done so results align with done_tick
            if (state_next_s == ST_DONE) begin
                bcd_r <= wdig_next_s;
                ovf_r <= wovf_next_s;
            end else begin
                bcd_r <= bcd_r;
                ovf_r <= ovf_r;
            end
        end
    end

    assign ready     = ready_r;
    assign done_tick = done_tick_r;
    assign ovf       = ovf_r;
    assign bcd3      = bcd_r[15:12];
    assign bcd2      = bcd_r[11:8];
    assign bcd1      = bcd_r[7:4];
    assign bcd0      = bcd_r[3:0];

endmodule

// File: tb/tb_bin2bcd_seq.sv
// Self-checking bench for bin2bcd_seq: expected results are pushed to a
// scoreboard when a start is driven and popped when done_tick appears.
module tb_bin2bcd_seq;

    localparam int W = 14;

    typedef struct packed {
        logic [15:0] dig;
        logic        ovf;
    } exp_t;

    logic         clk = 1'b0;
    logic         reset;
    logic         start;
    logic [W-1:0] bin;
    logic         ready;
    logic         done_tick;
    logic         ovf;
    logic [3:0]   bcd3, bcd2, bcd1, bcd0;

    int   total = 0;
    int   bad   = 0;
    exp_t sb_q[$];

    bin2bcd_seq #(.W(W), .CBIT(4)) dut (
        .clk       (clk),
        .reset     (reset),
        .start     (start),
        .bin       (bin),
        .ready     (ready),
        .done_tick (done_tick),
        .ovf       (ovf),
        .bcd3      (bcd3),
        .bcd2      (bcd2),
        .bcd1      (bcd1),
        .bcd0      (bcd0)
    );

    always #5 clk = ~clk;

    // Reference result computed arithmetically from the input value
    function automatic exp_t model(input int v);
        exp_t e;
        if (v > 9999) begin
            e.dig = 16'h9999;
            e.ovf = 1'b1;
        end else begin
            e.dig = {4'(v / 1000), 4'((v / 100) % 10), 4'((v / 10) % 10), 4'(v % 10)};
            e.ovf = 1'b0;
        end
        return e;
    endfunction

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Wait for done_tick (cycle 1 = first cycle after the accepting edge),
    // optionally pulsing stray starts at cycles x1/x2, then check the result.
    task automatic wait_done(input int exp_cyc, input int x1, input int x2);
        int   cyc;
        bit   got;
        exp_t e;
        cyc = 1;
        got = 1'b0;
        while (cyc <= 40 && !got) begin
            if (done_tick) begin
                got = 1'b1;
                total++;
                if (cyc !== exp_cyc) begin
                    bad++;
                    $display("FAIL latency: done_tick at cycle %0d, required %0d", cyc, exp_cyc);
                end
                e = sb_q.pop_front();
                total++;
                if ({bcd3, bcd2, bcd1, bcd0} !== e.dig) begin
                    bad++;
                    $display("FAIL digits: got %h, required %h", {bcd3, bcd2, bcd1, bcd0}, e.dig);
                end
                total++;
                if (ovf !== e.ovf) begin
                    bad++;
                    $display("FAIL ovf: got %b, required %b", ovf, e.ovf);
                end
                total++;
                if (ready !== 1'b0) begin
                    bad++;
                    $display("FAIL ready_in_done: got %b, required 0", ready);
                end
            end
            if (cyc == x1 || cyc == x2) begin
                start = 1'b1;
                bin   = W'($urandom_range(0, 16383));
            end else begin
                start = 1'b0;
            end
            if (!got) begin
                if (cyc == 1) begin
                    total++;
                    if (ready !== 1'b0 && exp_cyc > 1) begin
                        bad++;
                        $display("FAIL ready_fall: got %b, required 0", ready);
                    end
                end
                step();
                cyc++;
            end
        end
        if (!got) begin
            total++;
            bad++;
            $display("FAIL timeout: no done_tick within 40 cycles, required at cycle %0d", exp_cyc);
            if (sb_q.size() > 0) e = sb_q.pop_front();
        end else begin
            step();
            start = 1'b0;
            total++;
            if ({ready, done_tick} !== 2'b10) begin
                bad++;
                $display("FAIL ready_rise: ready/done_tick got %b%b, required 10", ready, done_tick);
            end
        end
    endtask

    task automatic run_conv(input int v, input int x1, input int x2);
        sb_q.push_back(model(v));
        bin   = W'(v);
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done((v > 9999) ? 1 : W + 1, x1, x2);
    endtask

    task automatic test_reset();
        total++;
        if ({ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL reset_state: got %b, required 1 0 0 0000",
                     {ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0});
        end
    endtask

    task automatic test_typical();
        run_conv(0, -1, -1);
        run_conv(9999, -1, -1);
        run_conv(4097, -1, -1);
        run_conv(255, -1, -1);
    endtask

    task automatic test_overflow();
        run_conv(12345, -1, -1);
        run_conv(7, -1, -1);
        run_conv(16383, -1, -1);
        run_conv(10000, -1, -1);
    endtask

    task automatic test_busy();
        run_conv(1234, 3, 15);
        // Cycle 16 is idle: a start here must be accepted
        run_conv(5678, -1, -1);
    endtask

    task automatic test_back_to_back();
        // start held high across the idle cycle restarts immediately
        sb_q.push_back(model(321));
        bin   = W'(321);
        start = 1'b1;
        step();
        wait_done(W + 1, 16, 16);
        bin = W'(9000);
        sb_q.push_back(model(9000));
        start = 1'b1;
        step();
        start = 1'b0;
        wait_done(W + 1, -1, -1);
    endtask

    task automatic test_reset_mid();
        bit seen;
        bin   = W'(8888);
        start = 1'b1;
        step();
        start = 1'b0;
        for (int c = 1; c < 6; c++) step();
        reset = 1'b1;
        step();
        reset = 1'b0;
        total++;
        if ({ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0} !== {1'b1, 1'b0, 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL mid_reset_clear: got %b, required 1 0 0 0000",
                     {ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0});
        end
        seen = 1'b0;
        for (int c = 0; c < 20; c++) begin
            if (done_tick) seen = 1'b1;
            step();
        end
        total++;
        if (seen !== 1'b0) begin
            bad++;
            $display("FAIL mid_reset_no_done: done_tick seen %b, required 0", seen);
        end
        run_conv(42, -1, -1);
    endtask

    task automatic test_hold();
        logic [19:0] snap;
        run_conv(3579, -1, -1);
        snap = {ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0};
        for (int c = 0; c < 100; c++) begin
            bin = W'($urandom_range(0, 16383));
            step();
            total++;
            if ({ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0} !== snap) begin
                bad++;
                $display("FAIL hold: cycle %0d got %h, required %h", c,
                         {ready, done_tick, ovf, bcd3, bcd2, bcd1, bcd0}, snap);
            end
        end
    endtask

    initial begin
        reset = 1'b1;
        start = 1'b1;
        bin   = W'(12345);
        step();
        step();
        reset = 1'b0;
        start = 1'b0;
        test_reset();
        test_typical();
        test_overflow();
        test_busy();
        test_back_to_back();
        test_reset_mid();
        test_hold();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
